// File: rtl/ncc_fetch_scheduler.sv
// Memory-port sequencer for the NCC engine: raster-fetches template then window,
// streams pixels through a 2-deep flow-through FIFO, then writes back the result.
module ncc_fetch_scheduler #(
  parameter int TEMP_ROWS = 16,
  parameter int TEMP_COLS = 16,
  parameter int WIN_ROWS  = 64,
  parameter int WIN_COLS  = 64,
  parameter int ROW_W     = 7,
  parameter int COL_W     = 7,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready_2_start,
  output logic              req,
  output logic              rd_wr,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              tem_win,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] write_data,
  output logic              set_done,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_is_tem,
  output logic              pix_valid,
  input  logic              pix_ready,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result_data,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_TEM, S_FETCH_WIN, S_WAIT_RES, S_WRITE, S_DONE
  } state_t;

  localparam logic [ROW_W-1:0] TR_LAST = ROW_W'(TEMP_ROWS - 1);
  localparam logic [COL_W-1:0] TC_LAST = COL_W'(TEMP_COLS - 1);
  localparam logic [ROW_W-1:0] WR_LAST = ROW_W'(WIN_ROWS - 1);
  localparam logic [COL_W-1:0] WC_LAST = COL_W'(WIN_COLS - 1);

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  cnt_row, last_row;
  logic [COL_W-1:0]  cnt_col, last_col;
  logic              last_tw;
  logic              inflight, inflight_tem;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_tem  [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] res_q;

  logic fetching, plane_win, can_issue, row_end, col_end, last_addr;
  logic wr_en, fifo_empty, push, pop;

  assign fetching   = (state == S_FETCH_TEM) || (state == S_FETCH_WIN);
  assign plane_win  = (state == S_FETCH_WIN);
  assign can_issue  = fetching && ((fifo_cnt + {1'b0, inflight}) < 2'd2);
  assign row_end    = cnt_row == (plane_win ? WR_LAST : TR_LAST);
  assign col_end    = cnt_col == (plane_win ? WC_LAST : TC_LAST);
  assign last_addr  = row_end && col_end;
  assign wr_en      = (state == S_WRITE);

  // Address lines show the live counter only while issuing, otherwise the last access.
  assign req        = can_issue || wr_en;
  assign rd_wr      = can_issue;
  assign row        = wr_en ? '0   : (can_issue ? cnt_row   : last_row);
  assign col        = wr_en ? '0   : (can_issue ? cnt_col   : last_col);
  assign tem_win    = wr_en ? 1'b0 : (can_issue ? plane_win : last_tw);
  assign write_data = wr_en ? res_q : '0;
  assign set_done   = (state == S_DONE);
  assign busy       = (state != S_IDLE);

  // Empty FIFO lets the returning word straight through, so steady state is 1 pixel/cycle.
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign pix_valid  = !fifo_empty || inflight;
  assign pix_data   = !fifo_empty ? fifo_data[rd_ptr] : (inflight ? read_data : '0);
  assign pix_is_tem = !fifo_empty ? fifo_tem[rd_ptr]  : (inflight && inflight_tem);
  assign push       = inflight && !(fifo_empty && pix_ready);
  assign pop        = !fifo_empty && pix_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (ready_2_start) state_nxt = S_FETCH_TEM;
      S_FETCH_TEM: if (can_issue && last_addr) state_nxt = S_FETCH_WIN;
      S_FETCH_WIN: if (can_issue && last_addr) state_nxt = S_WAIT_RES;
      S_WAIT_RES:  if (result_valid && fifo_empty && !inflight) state_nxt = S_WRITE;
      S_WRITE:     state_nxt = S_DONE;
      S_DONE:      if (!ready_2_start) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt_row      <= '0;
      cnt_col      <= '0;
      last_row     <= '0;
      last_col     <= '0;
      last_tw      <= 1'b0;
      inflight     <= 1'b0;
      inflight_tem <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
      res_q        <= '0;
    end else begin
      state        <= state_nxt;
      inflight     <= can_issue;
      inflight_tem <= (state == S_FETCH_TEM);
      if (req) begin
        last_row <= row;
        last_col <= col;
        last_tw  <= tem_win;
      end
      if (state == S_IDLE) begin
        cnt_row <= '0;
        cnt_col <= '0;
      end else if (can_issue) begin
        if (last_addr) begin
          cnt_row <= '0;
          cnt_col <= '0;
        end else if (col_end) begin
          cnt_row <= cnt_row + 1'b1;
          cnt_col <= '0;
        end else begin
          cnt_col <= cnt_col + 1'b1;
        end
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      if ((state == S_WAIT_RES) && (state_nxt == S_WRITE)) res_q <= result_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= read_data;
      fifo_tem[wr_ptr]  <= inflight_tem;
    end
  end

endmodule

// File: tb/tb_ncc_fetch_scheduler.sv
// Directed bench for ncc_fetch_scheduler: 4x4 template, 8x8 window, memory returns (row*col)%256.
module tb_ncc_fetch_scheduler;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, ready_2_start, pix_ready, result_valid;
  logic [DW-1:0] result_data, read_data, write_data, pix_data;
  logic          req, rd_wr, tem_win, set_done, pix_is_tem, pix_valid, busy;
  logic [6:0]    row, col;

  ncc_fetch_scheduler #(
    .TEMP_ROWS(4), .TEMP_COLS(4), .WIN_ROWS(8), .WIN_COLS(8),
    .ROW_W(7), .COL_W(7), .DATA_W(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ready_2_start(ready_2_start),
    .req(req), .rd_wr(rd_wr), .row(row), .col(col), .tem_win(tem_win),
    .read_data(read_data), .write_data(write_data), .set_done(set_done),
    .pix_data(pix_data), .pix_is_tem(pix_is_tem), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .result_valid(result_valid), .result_data(result_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: data one cycle after a read strobe, junk otherwise.
  always @(posedge clk)
    read_data <= (req && rd_wr) ? DW'((int'(row) * int'(col)) % 256) : 32'hDEAD_BEEF;

  int total = 0, bad = 0, cyc = 0;
  int pix_cnt, rd_cnt, wr_cnt, pix_err, addr_err, max_ahead;
  int first_cyc, last_cyc, wr_cyc, done_cyc, wr_addr, first_rd;
  logic done_seen, first_tem, p45_tem;
  logic [DW-1:0] wr_val, p45, first_val;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int i);
    int j;
    if (i < 16) return (i / 4) * 64 + (i % 4);
    j = i - 16;
    return 4096 + (j / 8) * 64 + (j % 8);
  endfunction

  function automatic int exp_pix(input int i);
    int j;
    if (i < 16) return (i / 4) * (i % 4);
    j = i - 16;
    return (j / 8) * (j % 8);
  endfunction

  task automatic clear_mon();
    pix_cnt = 0; rd_cnt = 0; wr_cnt = 0; pix_err = 0; addr_err = 0; max_ahead = 0;
    first_cyc = 0; last_cyc = 0; wr_cyc = 0; done_cyc = 0; wr_addr = -1; first_rd = -1;
    done_seen = 1'b0; first_tem = 1'b0; p45_tem = 1'b1; wr_val = '0; p45 = '0; first_val = '1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (req && rd_wr) begin
        if (rd_cnt == 0) first_rd = int'(tem_win) * 4096 + int'(row) * 64 + int'(col);
        if (int'(tem_win) * 4096 + int'(row) * 64 + int'(col) != exp_addr(rd_cnt)) addr_err++;
        rd_cnt++;
      end
      if (req && !rd_wr) begin
        wr_cnt++;
        wr_val  = write_data;
        wr_addr = int'(tem_win) * 4096 + int'(row) * 64 + int'(col);
        wr_cyc  = cyc;
      end
      if (set_done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
      if (pix_valid && pix_ready) begin
        if (pix_data !== DW'(exp_pix(pix_cnt)) || pix_is_tem !== (pix_cnt < 16)) pix_err++;
        if (pix_cnt == 0) begin
          first_cyc = cyc; first_val = pix_data; first_tem = pix_is_tem;
        end
        if (pix_cnt == 45) begin
          p45 = pix_data; p45_tem = pix_is_tem;
        end
        last_cyc = cyc;
        pix_cnt++;
      end
      if (rd_cnt - pix_cnt > max_ahead) max_ahead = rd_cnt - pix_cnt;
    end
  end

  task automatic wait_pix(input int n, input string tag);
    int k = 0;
    while (pix_cnt < n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    if (pix_cnt < n) chk(tag, DW'(pix_cnt), DW'(n));
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!set_done && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!set_done) chk(tag, DW'(set_done), 1);
  endtask

  int nodone, nreq;

  initial begin
    rst_n = 1'b0; ready_2_start = 1'b0; pix_ready = 1'b0;
    result_valid = 1'b0; result_data = '0;
    clear_mon();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", DW'(req), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done", DW'(set_done), 0);
    chk("rst_pvalid", DW'(pix_valid), 0);
    chk("rst_addr", DW'({tem_win, row, col}), 0);
    chk("rst_wdata", write_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Search A: free-running stream, early result ignored, then write-back.
    @(posedge clk); #1 ready_2_start = 1'b1; pix_ready = 1'b1;
    wait_pix(30, "a_to30");
    #1 result_valid = 1'b1; result_data = 32'h1;
    @(posedge clk); #1 result_valid = 1'b0;
    wait_pix(80, "a_to80");
    repeat (4) @(negedge clk);
    chk("a_early_wr", DW'(wr_cnt), 0);
    chk("a_wait_busy", DW'(busy), 1);
    chk("a_wait_done", DW'(set_done), 0);
    @(posedge clk); #1 result_valid = 1'b1; result_data = 32'h1234;
    wait_done("a_done_to");
    @(posedge clk); #1 result_valid = 1'b0;
    chk("a_pix_cnt", DW'(pix_cnt), 80);
    chk("a_pix_err", DW'(pix_err), 0);
    chk("a_p45", p45, 15);
    chk("a_p45_tem", DW'(p45_tem), 0);
    chk("a_rd_cnt", DW'(rd_cnt), 80);
    chk("a_addr_err", DW'(addr_err), 0);
    chk("a_first_rd", DW'(first_rd), 0);
    chk("a_rate", DW'(last_cyc - first_cyc), 79);
    chk("a_ahead", DW'(max_ahead), 1);
    chk("a_wr_cnt", DW'(wr_cnt), 1);
    chk("a_wr_data", wr_val, 32'h1234);
    chk("a_wr_addr", DW'(wr_addr), 0);
    chk("a_done_lat", DW'(done_cyc - wr_cyc), 1);

    // Level-high start after completion must not restart.
    nodone = 0; nreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (!set_done) nodone++;
      if (req) nreq++;
    end
    chk("hold_done", DW'(nodone), 0);
    chk("hold_noreq", DW'(nreq), 0);
    chk("hold_wr_cnt", DW'(wr_cnt), 1);
    @(posedge clk); #1 ready_2_start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_done", DW'(set_done), 0);
    chk("idle_busy", DW'(busy), 0);

    // Search B: stall the datapath after the 6th template pixel.
    clear_mon();
    @(posedge clk); #1 ready_2_start = 1'b1;
    wait_pix(6, "b_to6");
    #1 pix_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 pix_ready = 1'b1;
    wait_pix(80, "b_to80");
    repeat (3) @(negedge clk);
    chk("b_first_rd", DW'(first_rd), 0);
    chk("b_pix_cnt", DW'(pix_cnt), 80);
    chk("b_pix_err", DW'(pix_err), 0);
    chk("b_addr_err", DW'(addr_err), 0);
    chk("b_ahead", DW'(max_ahead), 2);
    @(posedge clk); #1 result_valid = 1'b1; result_data = 32'h55;
    wait_done("b_done_to");
    @(posedge clk); #1 result_valid = 1'b0; ready_2_start = 1'b0;
    chk("b_wr_data", wr_val, 32'h55);
    @(posedge clk); @(posedge clk);

    // Search C: async reset in the middle of the window fetch.
    clear_mon();
    #1 ready_2_start = 1'b1;
    wait_pix(30, "c_to30");
    #3 rst_n = 1'b0;
    #1;
    chk("c_rst_req", DW'({req, rd_wr}), 0);
    chk("c_rst_pvalid", DW'({pix_valid, pix_is_tem}), 0);
    chk("c_rst_pdata", pix_data, 0);
    chk("c_rst_busy", DW'({busy, set_done}), 0);
    chk("c_rst_addr", DW'({tem_win, row, col}), 0);
    ready_2_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    @(posedge clk); #1 ready_2_start = 1'b1;
    wait_pix(16, "c_to16");
    @(negedge clk);
    chk("c_first_val", first_val, 0);
    chk("c_first_tem", DW'(first_tem), 1);
    chk("c_first_rd", DW'(first_rd), 0);
    chk("c_pix_err", DW'(pix_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
